// File: rtl/instr_encoder_if.sv
// Loader-side field stream, program-memory write port and session status
// shared between the host loader (master) and instr_encoder (slave).
interface instr_encoder_if #(
   parameter int PROGRAM_DataWidth = 16,
   parameter int PC_WIDTH          = 8,
   parameter int NumOpCodeBits     = 5,
   parameter int SEL_WIDTH         = 2,
   parameter int ParamBits         = 8
);
   logic                         start;
   logic                         in_valid;
   logic                         in_ready;
   logic [NumOpCodeBits-1:0]     in_opcode;
   logic [SEL_WIDTH-1:0]         in_op1;
   logic [SEL_WIDTH-1:0]         in_op2;
   logic [ParamBits-1:0]         in_literal;
   logic                         in_last;
   logic                         mem_wr_en;
   logic [PC_WIDTH-1:0]          mem_adr;
   logic [PROGRAM_DataWidth-1:0] mem_data;
   logic                         busy;
   logic                         done;
   logic                         err;
   logic [1:0]                   err_code;
   logic [PC_WIDTH:0]            word_count;

   modport master (
      output start, in_valid, in_opcode, in_op1, in_op2, in_literal, in_last,
      input  in_ready, mem_wr_en, mem_adr, mem_data, busy, done, err,
             err_code, word_count
   );

   modport slave (
      input  start, in_valid, in_opcode, in_op1, in_op2, in_literal, in_last,
      output in_ready, mem_wr_en, mem_adr, mem_data, busy, done, err,
             err_code, word_count
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction fields into canonical 16-bit words and writes them to
// program memory from address 0; rejects opcodes the core does not execute.
module instr_encoder #(
   parameter int PROGRAM_DataWidth = 16,
   parameter int PC_WIDTH          = 8,
   parameter int NumOpCodeBits     = 5,
   parameter int SEL_WIDTH         = 2,
   parameter int ParamBits         = 8
) (
   input  logic             clk,
   input  logic             rst,
   instr_encoder_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCEPT = 2'b01,
      S_DONE   = 2'b10,
      S_ERROR  = 2'b11
   } state_t;

   localparam logic [PC_WIDTH:0] LAST_ADR = {1'b0, {PC_WIDTH{1'b1}}};
   localparam logic [PC_WIDTH:0] CNT_ONE  = {{PC_WIDTH{1'b0}}, 1'b1};

   // Returns {legal, word}; bit 10 and all unused fields stay zero.
   function automatic logic [16:0] f_encode(
      input logic [4:0] op,
      input logic [1:0] op1,
      input logic [1:0] op2,
      input logic [7:0] lit
   );
      logic [16:0] res;
      res = 17'd0;
      case (op)
         5'b00000: res = {1'b1, 16'h0000};
         5'b00001, 5'b00010, 5'b00011,
         5'b00100, 5'b00101, 5'b00110:
            res = {1'b1, op, 1'b0, op1, 3'b000, op2, 3'b000};
         5'b00111, 5'b01000, 5'b01001:
            res = {1'b1, op, 1'b0, op1, lit};
         5'b10000: res = {1'b1, op, 3'b000, lit};
         default:  res = 17'd0;
      endcase
      return res;
   endfunction

   state_t                       r_state;
   logic                         r_in_ready;
   logic                         r_mem_wr_en;
   logic [PC_WIDTH-1:0]          r_mem_adr;
   logic [PROGRAM_DataWidth-1:0] r_mem_data;
   logic                         r_busy;
   logic                         r_done;
   logic                         r_err;
   logic [1:0]                   r_err_code;
   logic [PC_WIDTH:0]            r_count;

   logic [16:0] w_enc;
   logic        w_legal;
   logic [15:0] w_word;
   logic        w_xfer;
   logic        w_at_last_adr;

   assign w_enc         = f_encode(bus.in_opcode, bus.in_op1, bus.in_op2, bus.in_literal);
   assign w_legal       = w_enc[16];
   assign w_word        = w_enc[15:0];
   assign w_xfer        = bus.in_valid && r_in_ready;
   assign w_at_last_adr = (r_count == LAST_ADR);

   // Session FSM with registered outputs; r_count doubles as the next write address.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_mem_wr_en <= 1'b0;
         r_mem_adr   <= {PC_WIDTH{1'b0}};
         r_mem_data  <= {PROGRAM_DataWidth{1'b0}};
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= 2'b00;
         r_count     <= {(PC_WIDTH+1){1'b0}};
      end else begin
         r_mem_wr_en <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  r_state    <= S_ACCEPT;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_err_code <= 2'b00;
                  r_count    <= {(PC_WIDTH+1){1'b0}};
               end
            end
            S_ACCEPT: begin
               if (w_xfer) begin
                  if (w_legal) begin
                     r_mem_wr_en <= 1'b1;
                     r_mem_adr   <= r_count[PC_WIDTH-1:0];
                     r_mem_data  <= w_word;
                     r_count     <= r_count + CNT_ONE;
                     if (bus.in_last) begin
                        r_state    <= S_DONE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                     end else if (w_at_last_adr) begin
                        // Top of memory reached with more to come: stop, never wrap.
                        r_state    <= S_ERROR;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 2'b10;
                     end
                  end else begin
                     r_state    <= S_ERROR;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_err      <= 1'b1;
                     r_err_code <= 2'b01;
                  end
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.mem_wr_en  = r_mem_wr_en;
   assign bus.mem_adr    = r_mem_adr;
   assign bus.mem_data   = r_mem_data;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.err_code   = r_err_code;
   assign bus.word_count = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes from a
// behavioural model, a forked monitor pops and compares every write pulse.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_encoder_if bus ();
   instr_encoder dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];
   int m_state;   // 0 idle, 1 accepting, 2 done, 3 error
   int m_count;
   int m_code;
   int legal_ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding from the field layout using plain arithmetic.
   function automatic bit model_enc(input int op, input int a, input int b, input int lit,
                                    output int word);
      word = 0;
      if (op == 0) word = 0;
      else if (op >= 1 && op <= 6) word = op * 2048 + a * 256 + b * 8;
      else if (op >= 7 && op <= 9) word = op * 2048 + a * 256 + lit;
      else if (op == 16) word = op * 2048 + lit;
      else return 1'b0;
      return 1'b1;
   endfunction

   task automatic monitor();
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (bus.mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: adr 0x%0h data 0x%0h, expected no write at %0t",
                        bus.mem_adr, bus.mem_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("wr_adr", 32'(bus.mem_adr), 32'(e[23:16]));
               chk("wr_data", 32'(bus.mem_data), 32'(e[15:0]));
            end
         end
      end
   endtask

   task automatic check_status();
      chk("in_ready", 32'(bus.in_ready), 32'(m_state == 1));
      chk("busy", 32'(bus.busy), 32'(m_state == 1));
      chk("done", 32'(bus.done), 32'(m_state == 2));
      chk("err", 32'(bus.err), 32'(m_state == 3));
      chk("err_code", 32'(bus.err_code), 32'(m_code));
      chk("word_count", 32'(bus.word_count), 32'(m_count));
   endtask

   task automatic model_reset();
      m_state = 0;
      m_count = 0;
      m_code  = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_status();
      chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("rst_mem_adr", 32'(bus.mem_adr), 32'd0);
      chk("rst_mem_data", 32'(bus.mem_data), 32'd0);
   endtask

   task automatic do_start();
      bus.in_valid = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (m_state != 1) begin
         m_state = 1;
         m_count = 0;
         m_code  = 0;
      end
      check_status();
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int op, input int a, input int b, input int lit, input bit last);
      int word;
      bit legal;
      bus.in_opcode  = op[4:0];
      bus.in_op1     = a[1:0];
      bus.in_op2     = b[1:0];
      bus.in_literal = lit[7:0];
      bus.in_last    = last;
      bus.in_valid   = 1'b1;
      chk("ready_before_xfer", 32'(bus.in_ready), 32'(m_state == 1));
      @(posedge clk);
      #1;
      if (m_state == 1) begin
         legal = model_enc(op, a, b, lit, word);
         if (legal) begin
            exp_q.push_back({m_count[7:0], word[15:0]});
            m_count++;
            if (last) m_state = 2;
            else if (m_count == 256) begin
               m_state = 3;
               m_code  = 2;
            end
         end else begin
            m_state = 3;
            m_code  = 1;
         end
      end
      check_status();
   endtask

   task automatic drain();
      idle(2);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   function automatic int rand_legal();
      return legal_ops[$urandom_range(0, 10)];
   endfunction

   initial begin
      int n;
      int op;
      bus.in_opcode = 5'd0;
      bus.in_op1 = 2'd0;
      bus.in_op2 = 2'd0;
      bus.in_literal = 8'd0;
      bus.in_last = 1'b0;
      fork
         monitor();
      join_none

      do_reset();

      // in_valid without start must not be accepted
      bus.in_opcode = 5'd1;
      bus.in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
      end
      drain();

      // Encoding sweep at addresses 0-4
      do_start();
      send(1, 1, 2, 0, 1'b0);
      send(6, 0, 3, 0, 1'b0);
      send(7, 2, 0, 3, 1'b0);
      send(9, 3, 0, 8'hA5, 1'b0);
      send(16, 0, 0, 8'h20, 1'b1);
      drain();
      check_status();

      // Back-to-back stream of 10 words, no bubbles
      do_start();
      for (int i = 0; i < 10; i++) begin
         send(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 255), i == 9);
         chk("b2b_wr_en", 32'(bus.mem_wr_en), 32'd1);
      end
      drain();

      // Illegal opcode as third word, then restart
      do_start();
      send(1, 1, 1, 0, 1'b0);
      send(9, 2, 0, 8'h5A, 1'b0);
      send(11, 0, 0, 0, 1'b1);
      drain();
      check_status();
      do_start();
      send(3, 2, 1, 0, 1'b1);
      drain();

      // Overflow without in_last, then with in_last on word 256
      do_start();
      for (int i = 0; i < 256; i++) send(rand_legal(), i % 4, (i / 4) % 4, i % 256, 1'b0);
      drain();
      check_status();
      do_start();
      for (int i = 0; i < 256; i++) send(rand_legal(), (i / 3) % 4, i % 4, 255 - i, i == 255);
      drain();
      check_status();

      // rst in the cycle after a transfer suppresses the next write
      do_start();
      send(2, 1, 3, 0, 1'b0);
      bus.in_opcode = 5'd4;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      model_reset();
      chk("rst_xfer_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check_status();
      drain();

      // Randomized sessions with occasional gaps and illegal opcodes
      for (int s = 0; s < 20; s++) begin
         do_start();
         n = $urandom_range(1, 30);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 9) == 0)
               op = ($urandom_range(0, 1) == 0) ? $urandom_range(10, 15) : $urandom_range(17, 31);
            else
               op = rand_legal();
            send(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), k == n - 1);
            if (m_state != 1) break;
         end
         drain();
         check_status();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
